// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings used by fetch and the control unit,
// plus the fetch-stage state encoding.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_SW    = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 3'b110;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// One-entry IF/ID pipeline slot: valid/ready handshake toward decode,
// loaded by fetch and cleared by a branch flush.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic               consume,
  input  logic               flush,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [OPCODE_W-1:0] id_opcode,
  output logic [ADDR_W-1:0]  id_pc
);

  logic valid_d;

  // Flush beats load; a load in the same cycle as a consume keeps the slot full.
  always_comb begin
    valid_d = id_valid;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else begin
      id_valid <= valid_d;
      if (load && !flush) begin
        id_instr <= load_instr;
        id_pc    <= load_pc;
      end
    end
  end

  assign id_opcode = id_instr[INSTR_W-1 -: OPCODE_W];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a req/ready instruction-memory
// port, and feeds a one-entry IF/ID slot with branch-redirect flushing.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ready,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [OPCODE_W-1:0] id_opcode,
  output logic [ADDR_W-1:0]   id_pc,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q;
  logic              pending_q;
  logic              can_accept;
  logic              capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= imem_req && !imem_ready;
      if (imem_req && !imem_ready) begin
        req_addr_q <= imem_addr;
      end
    end
  end

  // rst_n gates the request so it drops the instant reset is asserted,
  // abandoning any in-flight request.
  always_comb begin
    can_accept = !id_valid || id_ready;
    imem_req   = rst_n && (pending_q ||
                 (state_q == FETCH && can_accept && !redirect_valid));
    imem_addr  = pending_q ? req_addr_q : pc_q;
    capture    = (state_q == FETCH) && imem_req && imem_ready && !redirect_valid;

    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (capture) begin
      pc_d = imem_addr + 1'b1;
    end

    // DISCARD lasts exactly as long as a wrong-path request is still open;
    // a redirect landing on the completing cycle returns straight to FETCH.
    state_d = FETCH;
    if (pending_q && !imem_ready && (redirect_valid || state_q == DISCARD)) begin
      state_d = DISCARD;
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (capture),
    .load_instr(imem_rdata),
    .load_pc   (imem_addr),
    .consume   (id_ready),
    .flush     (redirect_valid),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .id_opcode (id_opcode),
    .id_pc     (id_pc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a zero-latency memory
// model whose ready signal is driven by the stimulus.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [2:0]  id_opcode;
  logic [7:0]  id_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .ADDR_W  (8),
    .INSTR_W (16),
    .RESET_PC(8'h00)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_opcode     (id_opcode),
    .id_pc         (id_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  always_comb imem_rdata = mem[imem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    #3;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %0b want 0", id_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %0b want 0", imem_req); end
    checks++; if (id_instr !== 16'h0000) begin errors++; $display("FAIL reset_id_instr: got %h want 0000", id_instr); end
    checks++; if (id_pc !== 8'h00) begin errors++; $display("FAIL reset_id_pc: got %h want 00", id_pc); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL release_req: got %0b want 1", imem_req); end
  endtask

  task automatic test_stream();
    logic [2:0] exp_op [4];
    exp_op[0] = OP_RTYPE; exp_op[1] = OP_LW; exp_op[2] = OP_SW; exp_op[3] = OP_BEQ;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_addr !== 8'(i)) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, imem_addr, 8'(i)); end
      cyc();
      checks++; if (id_opcode !== exp_op[i]) begin errors++; $display("FAIL stream_opcode[%0d]: got %b want %b", i, id_opcode, exp_op[i]); end
      checks++; if (id_pc !== 8'(i) || id_valid !== 1'b1) begin errors++; $display("FAIL stream_pc[%0d]: got pc=%h v=%0b want pc=%h v=1", i, id_pc, id_valid, 8'(i)); end
    end
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req[%0d]: got %0b want 0", k, imem_req); end
      checks++; if (id_pc !== 8'h03 || id_instr !== 16'hC000) begin errors++; $display("FAIL bp_hold[%0d]: got pc=%h instr=%h want pc=03 instr=c000", k, id_pc, id_instr); end
      cyc();
    end
    id_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h04) begin errors++; $display("FAIL bp_release: got req=%0b addr=%h want req=1 addr=04", imem_req, imem_addr); end
    cyc();
    checks++; if (id_pc !== 8'h04 || id_instr !== 16'h0104 || id_valid !== 1'b1) begin errors++; $display("FAIL bp_next: got pc=%h instr=%h v=%0b want pc=04 instr=0104 v=1", id_pc, id_instr, id_valid); end
  endtask

  task automatic test_wait_states();
    imem_ready = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h05) begin errors++; $display("FAIL wait_hold[%0d]: got req=%0b addr=%h want req=1 addr=05", k, imem_req, imem_addr); end
      cyc();
    end
    imem_ready = 1'b1;
    #1;
    cyc();
    checks++; if (id_pc !== 8'h05 || id_instr !== 16'h0105 || id_valid !== 1'b1) begin errors++; $display("FAIL wait_capture: got pc=%h instr=%h v=%0b want pc=05 instr=0105 v=1", id_pc, id_instr, id_valid); end
    checks++; if (imem_addr !== 8'h06) begin errors++; $display("FAIL wait_next_pc: got %h want 06", imem_addr); end
  endtask

  task automatic test_redirect_pending();
    cyc();
    imem_ready = 1'b0;
    #1;
    checks++; if (imem_addr !== 8'h07) begin errors++; $display("FAIL rdp_issue: got %h want 07", imem_addr); end
    cyc();
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h07) begin errors++; $display("FAIL rdp_during: got req=%0b addr=%h want req=1 addr=07", imem_req, imem_addr); end
    cyc();
    redirect_valid = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h07) begin errors++; $display("FAIL rdp_discard: got v=%0b req=%0b addr=%h want v=0 req=1 addr=07", id_valid, imem_req, imem_addr); end
    cyc();
    imem_ready = 1'b1;
    #1;
    checks++; if (imem_addr !== 8'h07) begin errors++; $display("FAIL rdp_hold: got %h want 07", imem_addr); end
    cyc();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rdp_drop: got v=%0b want 0", id_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin errors++; $display("FAIL rdp_target: got req=%0b addr=%h want req=1 addr=40", imem_req, imem_addr); end
    cyc();
    checks++; if (id_pc !== 8'h40 || id_instr !== 16'h4040 || id_valid !== 1'b1) begin errors++; $display("FAIL rdp_capture: got pc=%h instr=%h v=%0b want pc=40 instr=4040 v=1", id_pc, id_instr, id_valid); end
  endtask

  task automatic test_redirect_ready();
    redirect_valid = 1'b1; redirect_pc = 8'hFF;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdr_req: got %0b want 0", imem_req); end
    cyc();
    redirect_valid = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'hFF) begin errors++; $display("FAIL rdr_flush: got v=%0b req=%0b addr=%h want v=0 req=1 addr=ff", id_valid, imem_req, imem_addr); end
    cyc();
    checks++; if (id_pc !== 8'hFF || id_opcode !== 3'b111) begin errors++; $display("FAIL rdr_capture: got pc=%h op=%b want pc=ff op=111", id_pc, id_opcode); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL rdr_wrap: got %h want 00", imem_addr); end
  endtask

  task automatic test_reset_mid();
    imem_ready = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || id_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre: got req=%0b v=%0b want req=1 v=1", imem_req, id_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0 || id_pc !== 8'h00) begin errors++; $display("FAIL rmid_async: got v=%0b req=%0b pc=%h want v=0 req=0 pc=00", id_valid, imem_req, id_pc); end
    imem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL rmid_restart: got req=%0b addr=%h want req=1 addr=00", imem_req, imem_addr); end
    cyc();
    checks++; if (id_pc !== 8'h00 || id_instr !== 16'h0000 || id_valid !== 1'b1) begin errors++; $display("FAIL rmid_capture: got pc=%h instr=%h v=%0b want pc=00 instr=0000 v=1", id_pc, id_instr, id_valid); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 | 16'(i);
    mem[0] = 16'h0000; mem[1] = 16'h8000; mem[2] = 16'h4000; mem[3] = 16'hC000;
    mem[8'h40] = 16'h4040;
    mem[8'hFF] = 16'hE0FF;

    test_reset();
    test_stream();
    test_backpressure();
    test_wait_states();
    test_redirect_pending();
    test_redirect_ready();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
